state_dump_unit: RTL and testbench
==================================

Name: state_dump_unit

Overview:
Hardware successor to the end-of-simulation register and memory print-out. On a start pulse it freezes the CPU and walks GPR_N general registers, then DM_N data-memory words, through the existing asynchronous read ports. Each word goes out on a valid/ready stream tagged with source and index, so a bench, UART or JTAG bridge can capture machine state on silicon. It sits beside the single-cycle CPU and shares the GPR and DM read ports through a mux that is controlled by busy.

Parameters:
DATA_W, 32, width of register and memory words
GPR_N, 10, number of registers dumped, starting at index 0; legal range 1..32
GPR_AW, 5, GPR address width
DM_N, 10, number of DM words dumped, starting at word 0; legal range 1..2**DM_AW
DM_AW, 10, DM word-address width

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle request to begin a dump
cpu_stall  out  1  freezes PC and register/memory writes; equals busy
busy  out  1  high from the cycle after start is accepted until the final beat is accepted
done  out  1  one-cycle pulse in the cycle after the final beat is accepted
gpr_raddr  out  GPR_AW  GPR read address
gpr_rdata  in  DATA_W  GPR read data, combinational from gpr_raddr
dm_raddr  out  DM_AW  DM word read address
dm_rdata  in  DATA_W  DM read data, combinational from dm_raddr
dump_valid  out  1  beat available
dump_ready  in  1  consumer accepts the beat
dump_data  out  DATA_W  word value
dump_src  out  2  source tag: 00 = GPR, 01 = DM, 10 = checksum (optional feature only)
dump_index  out  max(GPR_AW,DM_AW)  index of the word within its source

Behaviour:
- Reset (reset==0 sampled at a rising edge):
  - State goes to IDLE.
  - busy, cpu_stall, done and dump_valid are 0.
  - gpr_raddr, dm_raddr, dump_index, dump_src and dump_data are 0.
  - Reset asserted mid-dump aborts the dump immediately; no done pulse follows.
- States:
  - IDLE: start==1 moves to S_GPR with idx=0. start is ignored in every other state.
  - S_GPR:
    - gpr_raddr=idx, dump_valid=1, dump_src=00, dump_data=gpr_rdata, dump_index=idx.
    - On valid&&ready: if idx==GPR_N-1, go to S_DM with idx=0; else idx++.
  - S_DM:
    - Same as S_GPR using the DM port, with dump_src=01.
    - On acceptance of idx==DM_N-1: go to S_CSUM if the optional feature is enabled, else FIN.
  - FIN: done=1 for exactly one cycle, then IDLE.
- Handshake:
  - A beat transfers on a rising edge where dump_valid && dump_ready.
  - While dump_ready==0, dump_data, dump_src and dump_index hold stable. They stay stable because the read address holds and the CPU is stalled.
  - dump_valid never drops without a transfer.
- Throughput: one beat per cycle while dump_ready stays high. Total dump of GPR_N+DM_N beats with no stalls occupies GPR_N+DM_N cycles in busy.
- Latency: start at edge N gives busy=1 and the first beat valid in cycle N+1.
- Index counter: width max(GPR_AW,DM_AW). It never wraps, because terminal compare happens before increment. GPR_N=32 is legal.
- busy deasserts in the FIN cycle. cpu_stall equals busy.
- start in the FIN cycle is ignored. A new dump needs start in IDLE.

Optional Feature:
- Macro: STATE_DUMP_CHECKSUM_EN.
- Defined:
  - A DATA_W accumulator XORs every accepted beat's dump_data. It clears on each accepted start and on reset.
  - After the last DM beat the block enters S_CSUM and emits one extra beat: dump_src=10, dump_index=0, dump_data=accumulator. Acceptance of this beat leads to FIN.
- Undefined: no accumulator, no S_CSUM state, and dump_src never equals 10.

Decomposition:
- Package state_dump_pkg holds:
  - state enum {IDLE,S_GPR,S_DM,S_CSUM,FIN}
  - source codes SRC_GPR=2'b00, SRC_DM=2'b01, SRC_CSUM=2'b10
  - function for max index width
- One sub-module, dump_index_counter: loadable counter with enable (valid&&ready), clear, and terminal-count compare against a runtime limit input.

Test Plan:
- GPR r0..r9 = 0,1,...,9 and DM[0..9] = A0..A9, dump_ready tied 1, pulse start → 20 consecutive beats: src 00 indices 0..9 data 0..9, then src 01 indices 0..9 data A0..A9; done one cycle after the last beat; busy high exactly 20 cycles.
- Same preload, dump_ready toggled 1,0,0,1,... → beats hold stable while ready==0; same 20 values in order; no duplicates or drops.
- start pulsed again during beat 5 → ignored; exactly 20 beats total and one done pulse.
- reset driven 0 during DM beat 3 → next cycle busy=0, dump_valid=0, no done; a later start restarts at GPR index 0.
- With STATE_DUMP_CHECKSUM_EN: GPR = {0x1,0x2,0,...}, DM all 0 → 21st beat has src=10 and data=0x00000003, then done.
- GPR_N=32 and DM_N=1 → GPR indices 0..31 then DM index 0; no counter wrap; 33 beats total.

Source files
------------

// File: rtl/state_dump_pkg.sv
// Shared types for the machine-state dump unit: FSM states, stream source tags and
// the index-width helper used to size the dump index.
package state_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    S_GPR,
    S_DM,
    S_CSUM,
    FIN
  } state_e;

  localparam logic [1:0] SRC_GPR  = 2'b00;
  localparam logic [1:0] SRC_DM   = 2'b01;
  localparam logic [1:0] SRC_CSUM = 2'b10;

  function automatic int unsigned idx_width(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/dump_index_counter.sv
// Word index counter for the dump walk: clears to zero, advances on each accepted beat and
// flags the terminal count against a runtime limit so it never has to wrap.
module dump_index_counter #(
  parameter int unsigned W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         term
);

  assign term = (count == limit);

  // The terminal beat reloads zero so the next source starts at index 0.
  always_ff @(posedge clock) begin
    if (!reset || clr || (en && term)) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/state_dump_unit.sv
// Freezes the CPU and streams GPR then DM contents out over valid/ready, tagged by source
// and index. Define STATE_DUMP_CHECKSUM_EN to append an XOR checksum beat.
module state_dump_unit
  import state_dump_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned GPR_N  = 10,
  parameter int unsigned GPR_AW = 5,
  parameter int unsigned DM_N   = 10,
  parameter int unsigned DM_AW  = 10
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start,
  output logic                                  cpu_stall,
  output logic                                  busy,
  output logic                                  done,
  output logic [GPR_AW-1:0]                     gpr_raddr,
  input  logic [DATA_W-1:0]                     gpr_rdata,
  output logic [DM_AW-1:0]                      dm_raddr,
  input  logic [DATA_W-1:0]                     dm_rdata,
  output logic                                  dump_valid,
  input  logic                                  dump_ready,
  output logic [DATA_W-1:0]                     dump_data,
  output logic [1:0]                            dump_src,
  output logic [idx_width(GPR_AW, DM_AW)-1:0]   dump_index
);

  localparam int unsigned IW = idx_width(GPR_AW, DM_AW);

  state_e        state_q;
  logic [IW-1:0] idx;
  logic [IW-1:0] limit;
  logic          term;
  logic          fire;
  logic          cnt_en;

  assign fire   = dump_valid && dump_ready;
  assign cnt_en = fire && ((state_q == S_GPR) || (state_q == S_DM));
  assign limit  = (state_q == S_GPR) ? IW'(GPR_N - 1) : IW'(DM_N - 1);

  dump_index_counter #(
    .W (IW)
  ) u_idx (
    .clock (clock),
    .reset (reset),
    .clr   (state_q == IDLE),
    .en    (cnt_en),
    .limit (limit),
    .count (idx),
    .term  (term)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      unique case (state_q)
        IDLE:   if (start) state_q <= S_GPR;
        S_GPR:  if (fire && term) state_q <= S_DM;
`ifdef STATE_DUMP_CHECKSUM_EN
        S_DM:   if (fire && term) state_q <= S_CSUM;
        S_CSUM: if (fire) state_q <= FIN;
`else
        S_DM:   if (fire && term) state_q <= FIN;
`endif
        FIN:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef STATE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      csum_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      csum_q <= '0;
    end else if (cnt_en) begin
      csum_q <= csum_q ^ dump_data;
    end
  end
`endif

  // Outputs decode straight from the registered state and index; the read address
  // holds while ready is low, so the beat stays stable.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    gpr_raddr  = '0;
    dm_raddr   = '0;
    dump_src   = SRC_GPR;
    dump_index = '0;
    dump_data  = '0;
    unique case (state_q)
      S_GPR: begin
        busy       = 1'b1;
        gpr_raddr  = idx[GPR_AW-1:0];
        dump_index = idx;
        dump_data  = gpr_rdata;
      end
      S_DM: begin
        busy       = 1'b1;
        dm_raddr   = idx[DM_AW-1:0];
        dump_src   = SRC_DM;
        dump_index = idx;
        dump_data  = dm_rdata;
      end
`ifdef STATE_DUMP_CHECKSUM_EN
      S_CSUM: begin
        busy      = 1'b1;
        dump_src  = SRC_CSUM;
        dump_data = csum_q;
      end
`endif
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

  assign cpu_stall  = busy;
  assign dump_valid = busy;

endmodule

// File: tb/tb_state_dump_unit.sv
// Bench for state_dump_unit: queue-based reference of the expected beat stream, checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_state_dump_unit;

`ifdef STATE_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  typedef struct {
    logic [1:0]  src;
    int unsigned idx;
    logic [31:0] data;
  } beat_t;

  typedef enum {M_IDLE, M_RUN, M_FIN} mphase_e;

  logic clock = 1'b0;
  logic reset;
  logic start;
  logic dump_ready;
  logic sel;

  logic [31:0] gpr_mem [32];
  logic [31:0] dm_mem  [1024];

  logic        a_stall, a_busy, a_done, a_valid;
  logic [4:0]  a_graddr;
  logic [9:0]  a_draddr, a_index;
  logic [31:0] a_grdata, a_drdata, a_data;
  logic [1:0]  a_src;

  logic        b_stall, b_busy, b_done, b_valid;
  logic [4:0]  b_graddr;
  logic [9:0]  b_draddr, b_index;
  logic [31:0] b_grdata, b_drdata, b_data;
  logic [1:0]  b_src;

  logic        d_stall, d_busy, d_done, d_valid;
  logic [9:0]  d_index;
  logic [31:0] d_data;
  logic [1:0]  d_src;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int beat_cnt = 0;
  bit armed = 1'b0;
  mphase_e mphase = M_IDLE;
  beat_t exp_q[$];

  always #5 clock = ~clock;

  assign a_grdata = gpr_mem[a_graddr];
  assign a_drdata = dm_mem[a_draddr];
  assign b_grdata = gpr_mem[b_graddr];
  assign b_drdata = dm_mem[b_draddr];

  assign d_stall = sel ? b_stall : a_stall;
  assign d_busy  = sel ? b_busy  : a_busy;
  assign d_done  = sel ? b_done  : a_done;
  assign d_valid = sel ? b_valid : a_valid;
  assign d_index = sel ? b_index : a_index;
  assign d_data  = sel ? b_data  : a_data;
  assign d_src   = sel ? b_src   : a_src;

  state_dump_unit dut_a (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .cpu_stall  (a_stall),
    .busy       (a_busy),
    .done       (a_done),
    .gpr_raddr  (a_graddr),
    .gpr_rdata  (a_grdata),
    .dm_raddr   (a_draddr),
    .dm_rdata   (a_drdata),
    .dump_valid (a_valid),
    .dump_ready (dump_ready),
    .dump_data  (a_data),
    .dump_src   (a_src),
    .dump_index (a_index)
  );

  state_dump_unit #(
    .GPR_N (32),
    .DM_N  (1)
  ) dut_b (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .cpu_stall  (b_stall),
    .busy       (b_busy),
    .done       (b_done),
    .gpr_raddr  (b_graddr),
    .gpr_rdata  (b_grdata),
    .dm_raddr   (b_draddr),
    .dm_rdata   (b_drdata),
    .dump_valid (b_valid),
    .dump_ready (dump_ready),
    .dump_data  (b_data),
    .dump_src   (b_src),
    .dump_index (b_index)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected stream: every GPR word, every DM word, then the XOR of them all if enabled.
  task automatic build_stream();
    int gn;
    int dn;
    logic [31:0] x;
    gn = sel ? 32 : 10;
    dn = sel ? 1 : 10;
    x  = '0;
    exp_q.delete();
    for (int i = 0; i < gn; i++) begin
      exp_q.push_back('{2'b00, i, gpr_mem[i]});
      x ^= gpr_mem[i];
    end
    for (int i = 0; i < dn; i++) begin
      exp_q.push_back('{2'b01, i, dm_mem[i]});
      x ^= dm_mem[i];
    end
`ifdef STATE_DUMP_CHECKSUM_EN
    exp_q.push_back('{2'b10, 0, x});
`endif
  endtask

  task automatic model_step();
    bit run;
    run = (mphase == M_RUN);
    if (run) begin
      chk("valid", d_valid, 1);
      chk("data", d_data, exp_q[0].data);
      chk("src", d_src, exp_q[0].src);
      chk("index", d_index, exp_q[0].idx);
    end else begin
      chk("valid", d_valid, 0);
    end
    chk("busy", d_busy, run);
    chk("stall", d_stall, run);
    chk("done", d_done, mphase == M_FIN);
    if (d_busy) busy_cnt++;
    if (d_done) done_cnt++;
    if (!reset) begin
      mphase = M_IDLE;
      exp_q.delete();
    end else begin
      case (mphase)
        M_IDLE: if (start) begin
          build_stream();
          mphase = M_RUN;
        end
        M_RUN: if (dump_ready) begin
          void'(exp_q.pop_front());
          beat_cnt++;
          if (exp_q.size() == 0) mphase = M_FIN;
        end
        default: mphase = M_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic preload_seq();
    for (int i = 0; i < 32; i++) gpr_mem[i] = i;
    for (int i = 0; i < 1024; i++) dm_mem[i] = 32'hA0 + i;
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready. again: loop cycle of a
  // second start pulse (-1 for none).
  task automatic run_dump(input int mode, input int again, input int nb);
    int b0;
    int d0;
    bit fin;
    b0  = beat_cnt;
    d0  = done_cnt;
    fin = 1'b0;
    start = 1'b1;
    dump_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("first_src", d_src, 0);
    chk("first_index", d_index, 0);
    chk("first_data", d_data, gpr_mem[0]);
    for (int c = 0; c < 2000 && !fin; c++) begin
      case (mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (c % 3 == 0);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      start = (c == again);
      tick();
      if (mphase == M_IDLE) fin = 1'b1;
    end
    start = 1'b0;
    chk("timeout", fin, 1);
    chk("beat_total", beat_cnt - b0, nb);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  initial begin
    int b0;
    int d0;
    int k0;
    reset = 1'b0;
    start = 1'b0;
    dump_ready = 1'b0;
    sel = 1'b0;
    for (int i = 0; i < 32; i++) gpr_mem[i] = '0;
    for (int i = 0; i < 1024; i++) dm_mem[i] = '0;

    fork
      forever begin
        @(negedge clock);
        if (armed) model_step();
      end
    join_none

    repeat (2) tick();
    chk("rst_busy", a_busy, 0);
    chk("rst_stall", a_stall, 0);
    chk("rst_done", a_done, 0);
    chk("rst_valid", a_valid, 0);
    chk("rst_graddr", a_graddr, 0);
    chk("rst_draddr", a_draddr, 0);
    chk("rst_index", a_index, 0);
    chk("rst_src", a_src, 0);
    chk("rst_data", a_data, 0);
    chk("rst_b_busy", b_busy, 0);
    reset = 1'b1;
    armed = 1'b1;
    tick();

    // Sequential preload, ready high: 20 beats back to back.
    preload_seq();
    b0 = beat_cnt;
    d0 = done_cnt;
    k0 = busy_cnt;
    start = 1'b1;
    dump_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_first_valid", d_valid, 1);
    chk("t1_first_busy", d_busy, 1);
    chk("t1_first_data", d_data, 0);
    repeat (10) tick();
    chk("t1_dm0_src", d_src, 1);
    chk("t1_dm0_index", d_index, 0);
    chk("t1_dm0_data", d_data, 32'hA0);
    repeat (10) tick();
`ifdef STATE_DUMP_CHECKSUM_EN
    chk("t1_csum_src", d_src, 2);
    tick();
`endif
    chk("t1_done", d_done, 1);
    chk("t1_busy_end", d_busy, 0);
    tick();
    chk("t1_beats", beat_cnt - b0, 20 + CS);
    chk("t1_busy_cycles", busy_cnt - k0, 20 + CS);
    chk("t1_done_pulses", done_cnt - d0, 1);
    tick();

    // Back-pressure pattern, then a spurious start during beat 5.
    run_dump(1, -1, 20 + CS);
    tick();
    run_dump(0, 5, 20 + CS);
    tick();

    // Reset during DM beat 3 aborts without done; a fresh start restarts at GPR 0.
    pulse_reset();
    d0 = done_cnt;
    start = 1'b1;
    dump_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    chk("t4_pre_src", d_src, 1);
    chk("t4_pre_index", d_index, 3);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t4_busy", d_busy, 0);
    chk("t4_valid", d_valid, 0);
    repeat (4) tick();
    chk("t4_no_done", done_cnt - d0, 0);
    run_dump(0, -1, 20 + CS);
    tick();

    // Checksum pattern: GPR {1,2,0...}, DM all zero.
    pulse_reset();
    for (int i = 0; i < 32; i++) gpr_mem[i] = '0;
    for (int i = 0; i < 1024; i++) dm_mem[i] = '0;
    gpr_mem[0] = 32'h1;
    gpr_mem[1] = 32'h2;
    start = 1'b1;
    dump_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
`ifdef STATE_DUMP_CHECKSUM_EN
    chk("t5_csum_src", d_src, 2);
    chk("t5_csum_index", d_index, 0);
    chk("t5_csum_data", d_data, 32'h3);
    tick();
`endif
    chk("t5_done", d_done, 1);
    repeat (2) tick();

    // Full 32-register walk with a single DM word.
    pulse_reset();
    sel = 1'b1;
    preload_seq();
    k0 = busy_cnt;
    run_dump(0, -1, 33 + CS);
    chk("t6_busy_cycles", busy_cnt - k0, 33 + CS);
    tick();

    // Random contents, random back-pressure, random stray start.
    for (int t = 0; t < 8; t++) begin
      pulse_reset();
      sel = t[0];
      for (int i = 0; i < 32; i++) gpr_mem[i] = $urandom;
      for (int i = 0; i < 16; i++) dm_mem[i] = $urandom;
      run_dump(2, $urandom_range(0, 40), (sel ? 33 : 20) + CS);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
